carry_skip_mp_seq: RTL and testbench
====================================

# carry_skip_mp_seq

Multi-precision add/subtract sequencer built around one shared `carry_skip_16bit` adder. It accepts a WORDS×16-bit operand pair over a valid/ready handshake and runs the pair through the 16-bit adder one word per cycle, LSW first, chaining carry through a register. It returns the full-width sum, carry-out and signed overflow over a second valid/ready handshake. It sits between wide-operand producers (accumulators, address generators) and the single 16-bit carry-skip datapath, trading latency for area.

## Interface
- `WORDS`, 4: number of 16-bit words per operand (≥2); operand width `W = 16*WORDS`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready` at a rising edge.
- `a` input W: operand A.
- `b` input W: operand B.
- `cin` input 1: carry-in (ignored when `sub=1`).
- `sub` input 1: 1 = compute A−B.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid && out_ready` at a rising edge.
- `sum` output W: result.
- `cout` output 1: final carry out of the MSW (for subtraction, 1 = no borrow).
- `ovf` output 1: two's-complement overflow of the W-bit operation.

## Operation
- FSM states: IDLE, RUN, DONE. `rst` forces IDLE, word counter 0, carry register 0, and all operand/result registers 0.
- IDLE: `in_ready`=1. On handshake, capture `a`, `b_eff = sub ? ~b : b`, carry register `= sub ? 1 : cin`, and the sign bits `a[W-1]` and `b_eff[W-1]`. Then go to RUN with count=0.
- RUN: the adder sees the low word of the A and b_eff shift registers and the carry register. Each edge:
  - shift the 16-bit adder sum into the top of the result shift register;
  - shift both operand registers right by 16;
  - load the carry register with the adder `cout`;
  - count++.
- At the edge where count=WORDS−1, go to DONE.
- DONE: `out_valid`=1. `sum` is the result register, `cout` is the carry register, and `ovf = (a_sign == b_eff_sign) && (sum[W-1] != a_sign)`. On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE, so a request and a result never overlap. `in_valid` in RUN or DONE is ignored and not queued.
- Outputs hold stable throughout DONE regardless of input changes.
- Arithmetic is modulo 2^W. No saturation.

## Timing
- Reset values: `in_ready`=1 from the first cycle after reset; `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- Latency: accept edge E0. Words 0..WORDS−1 are processed on edges E1..E_WORDS. `out_valid` is high in the cycle after E_WORDS, i.e. WORDS cycles after acceptance.
- Minimum initiation interval is WORDS+2 cycles: the accept cycle, WORDS RUN cycles, and at least one DONE cycle.
- The adder path is combinational within one cycle. Register-to-register it is 16-bit adder + 1 mux.
- `rst` in any state returns to IDLE on that edge and aborts the in-flight operation without emitting a result. `rst` has priority over simultaneous handshakes.
- `out_ready` held high in DONE gives a one-cycle `out_valid` pulse.

## Structure
- Shared package `carry_skip_pkg`:
  - `WORD_W = 16`;
  - state enum `{IDLE, RUN, DONE}`;
  - counter width function `clog2(WORDS)`.
- One sub-module, `carry_skip_16bit`, instantiated once as the shared datapath. All other logic (FSM, counter, shift registers, operand inversion, overflow) lives in this block.

## Test plan
All scenarios use WORDS=4.
- **Word-boundary carry:** a=0x0000_0000_0000_FFFF, b=0x1, cin=0, sub=0 → sum=0x0000_0000_0001_0000, cout=0, ovf=0. `out_valid` rises exactly 4 cycles after the accept edge.
- **Full carry ripple:** a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 → sum=0, cout=1, ovf=0.
- **Subtraction with borrow:** sub=1, a=5, b=7 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then sub=1, a=7, b=5 → sum=2, cout=1.
- **Signed overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- **Output backpressure:** hold `out_ready`=0 for 10 cycles in DONE while driving `in_valid`=1 with new operands. The sum, cout, ovf and `out_valid` outputs stay constant, `in_ready` stays 0, and the new request is accepted only on the first IDLE cycle after `out_ready`.
- **Reset mid-operation:** assert `rst` for one cycle while count=2 in RUN. The next cycle shows `in_ready`=1, `out_valid`=0, sum=0. No result is emitted for the aborted request, and a following request completes correctly.

Source files
------------

// File: rtl/carry_skip_pkg.sv
// Shared definitions for the multi-precision carry-skip sequencer.
package carry_skip_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/carry_skip_16bit.sv
// 16-bit carry-skip adder: 4-bit ripple blocks, each block's carry-in bypasses
// the block when every bit in it propagates.
module carry_skip_16bit
  import carry_skip_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int BLK    = 4;
  localparam int NBLK   = WORD_W / BLK;

  logic [NBLK:0]       blk_c;
  logic [WORD_W-1:0]   prop;
  logic                rc;

  assign prop = a ^ b;

  always_comb begin
    blk_c    = '0;
    sum      = '0;
    rc       = 1'b0;
    blk_c[0] = cin;
    for (int k = 0; k < NBLK; k++) begin
      rc = blk_c[k];
      for (int i = 0; i < BLK; i++) begin
        sum[k*BLK+i] = prop[k*BLK+i] ^ rc;
        rc = (a[k*BLK+i] & b[k*BLK+i]) | (prop[k*BLK+i] & rc);
      end
      // An all-propagate block passes its incoming carry straight through.
      blk_c[k+1] = (&prop[k*BLK +: BLK]) ? blk_c[k] : rc;
    end
  end

  assign cout = blk_c[NBLK];

endmodule

// File: rtl/carry_skip_mp_seq.sv
// Multi-precision add/subtract: streams WORDS 16-bit slices LSW first through
// one shared carry_skip_16bit, chaining the carry through a register.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid is never withdrawn by this block once raised, and in_ready is high
// only in IDLE, so a request and a result never overlap.
module carry_skip_mp_seq
  import carry_skip_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W  = WORD_W * WORDS;
  localparam int CW = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);

  state_t            state;
  logic [CW-1:0]     count;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      res_q;
  logic              carry_q;
  logic              a_sign;
  logic              b_sign;
  logic [W-1:0]      b_eff;
  logic [WORD_W-1:0] word_sum;
  logic              word_cout;

  assign b_eff = sub ? ~b : b;

  carry_skip_16bit u_adder (
    .a    (a_q[WORD_W-1:0]),
    .b    (b_q[WORD_W-1:0]),
    .cin  (carry_q),
    .sum  (word_sum),
    .cout (word_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b_eff;
            carry_q  <= sub ? 1'b1 : cin;
            a_sign   <= a[W-1];
            b_sign   <= b_eff[W-1];
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Completed words enter at the top so word 0 lands at the bottom last.
          res_q   <= {word_sum, res_q[W-1:WORD_W]};
          a_q     <= {{WORD_W{1'b0}}, a_q[W-1:WORD_W]};
          b_q     <= {{WORD_W{1'b0}}, b_q[W-1:WORD_W]};
          carry_q <= word_cout;
          count   <= count + 1'b1;
          if (count == CW'(WORDS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = res_q;
  assign cout = carry_q;
  assign ovf  = (a_sign == b_sign) && (res_q[W-1] != a_sign);

endmodule

// File: tb/tb_carry_skip_mp_seq.sv
// Bench for carry_skip_mp_seq (WORDS=4): vector table, random ops against an
// arithmetic model, backpressure and mid-run reset sequences.
module tb_carry_skip_mp_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  carry_skip_mp_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t         vecs[7];
  logic [W+1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W:0]   t;
    logic [W-1:0] be;
    logic         o;
    be = msub ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, be} + (W+1)'(msub ? 1'b1 : mcin);
    o  = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
    return {t[W], o, t[W-1:0]};
  endfunction

  // driver: present a request and hold it until accepted
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                          input logic tsub, input logic [W+1:0] exp, input bit push);
    int wait_cnt;
    a = ta; b = tb_; cin = tcin; sub = tsub;
    in_valid = 1'b1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end
    if (push) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  // scoreboard: wait for out_valid, check latency, pop and compare
  task automatic wait_result(input string name);
    int lat;
    logic [W+1:0] e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, W'(lat), W'(WORDS));
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_queue: got result expected none", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_sum"}, sum, e[W-1:0]);
      check({name, "_cout"}, W'(cout), W'(e[W+1]));
      check({name, "_ovf"}, W'(ovf), W'(e[W]));
    end
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_ov_drop"}, W'(out_valid), W'(0));
    check({name, "_ir_back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6] = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h7, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum", sum, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf", W'(ovf), W'(0));

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
               {vecs[i].cout, vecs[i].ovf, vecs[i].sum}, 1'b1);
      wait_result($sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      start_op(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
      wait_result($sformatf("rand%0d", i));
      release_result($sformatf("rand%0d", i));
    end

    // Backpressure: DONE holds while a new request waits.
    begin
      logic [W-1:0] hs;
      logic hc, ho;
      start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
               model(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0), 1'b1);
      wait_result("bp_first");
      hs = sum; hc = cout; ho = ovf;
      a = 64'hFFFF_0000_FFFF_0000; b = 64'h0001_0000_0001_0000; cin = 1'b1; sub = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        check("bp_sum_hold", sum, hs);
        check("bp_flags_hold", W'({cout, ovf}), W'({hc, ho}));
        check("bp_out_valid", W'(out_valid), W'(1));
        check("bp_in_ready", W'(in_ready), W'(0));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_idle_ir", W'(in_ready), W'(1));
      check("bp_idle_ov", W'(out_valid), W'(0));
      exp_q.push_back(model(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, 1'b0));
      tick();
      in_valid = 1'b0;
      check("bp_accepted", W'(in_ready), W'(0));
      wait_result("bp_second");
      release_result("bp_second");
    end

    // Reset while count=2 aborts the operation.
    start_op(64'h0123_4567_89AB_CDEF, 64'h1, 1'b0, 1'b0, '0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ir", W'(in_ready), W'(1));
    check("mid_rst_ov", W'(out_valid), W'(0));
    check("mid_rst_sum", sum, '0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      check("mid_rst_no_result", W'(seen), W'(0));
    end
    start_op(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 66'h0_0001_0000_0000_0000, 1'b1);
    wait_result("post_rst");
    release_result("post_rst");

    check("queue_empty", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
